ram36_ctrl: RTL and testbench

RAM36_CTRL -- requirements
Module: ram36_ctrl

---
 rtl/ram36_ctrl_pkg.sv | 23 ++
 rtl/ram36_rr_arb.sv | 40 ++++
 rtl/ram36_ctrl.sv | 150 +++++++++++++++
 tb/tb_ram36_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram36_ctrl_pkg.sv
// Shared constants, FSM state and read-tracking tag for the dual-requester RAM controller.
package ram36_ctrl_pkg;

    localparam int DEPTH      = 2048;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram36_rr_arb.sv
// Two-way round-robin arbiter; grant is combinational, priority flips after every grant.
module ram36_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio_b_r;

    // Grant selection from request vector and current priority
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio_b_r ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

    // Priority register: the requester not granted most recently wins contention
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b_r <= 1'b0;
        end else if (gnt[0]) begin
            prio_b_r <= 1'b1;
        end else if (gnt[1]) begin
            prio_b_r <= 1'b0;
        end else begin
            prio_b_r <= prio_b_r;
        end
    end

endmodule

// File: rtl/ram36_ctrl.sv
// Dual-requester single-port RAM controller: post-reset clear sweep, round-robin access,
// registered RAM command and in-order read responses tracked by a tag shift register.
module ram36_ctrl
    import ram36_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                RD_LAT     = RD_LAT_DEF,
    parameter bit                INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   init_cnt_r;
    logic                sweep_done_r;
    logic                arb_en_s;
    logic [1:0]          gnt_s;
    logic                acc_s;
    logic                acc_id_s;
    logic                acc_we_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_wdata_s;
    rd_tag_t             pipe_r [0:RD_LAT];

    // Requests are only eligible in RUN and never during the reset cycle
    assign arb_en_s  = (state_r == ST_RUN) && !rst;
    assign req_ready = gnt_s;

    ram36_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en_s),
        .req (req_valid),
        .gnt (gnt_s)
    );

    // Select the command fields of the granted requester
    always_comb begin
        acc_s       = |gnt_s;
        acc_id_s    = gnt_s[1];
        acc_we_s    = req_we[acc_id_s];
        acc_addr_s  = acc_id_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        acc_wdata_s = acc_id_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end

    // Next-state logic: leave INIT one cycle after the last sweep write is issued
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_done_r) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_INIT;
        endcase
    end

    // State register and init_done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= INIT_EN ? ST_INIT : ST_RUN;
            init_done <= 1'b0;
        end else begin
            state_r   <= state_s;
            init_done <= (state_s == ST_RUN);
        end
    end

    // Registered RAM command: sweep writes in INIT, granted request in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_r   <= '0;
            sweep_done_r <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else if (state_r == ST_INIT) begin
            ram_en    <= !sweep_done_r;
            ram_we    <= !sweep_done_r;
            ram_addr  <= init_cnt_r;
            ram_wdata <= INIT_VALUE;
            if (!sweep_done_r) begin
                init_cnt_r   <= init_cnt_r + ADDR_W'(1);
                sweep_done_r <= (init_cnt_r == LAST_ADDR);
            end else begin
                init_cnt_r   <= init_cnt_r;
                sweep_done_r <= sweep_done_r;
            end
        end else begin
            ram_en    <= acc_s;
            ram_we    <= acc_s & acc_we_s;
            ram_addr  <= acc_s ? acc_addr_s : ram_addr;
            ram_wdata <= acc_s ? acc_wdata_s : ram_wdata;
        end
    end

    // In-flight read tags; the tag reaches the last stage in the cycle ram_rdata is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0].vld <= acc_s & ~acc_we_s;
            pipe_r[0].id  <= acc_id_s;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Response register: strobe the owner, hold data between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
        end else if (pipe_r[RD_LAT].vld) begin
            rsp_valid <= id_to_onehot(pipe_r[RD_LAT].id);
            rsp_data  <= ram_rdata;
        end else begin
            rsp_valid <= 2'b00;
            rsp_data  <= rsp_data;
        end
    end

endmodule

// File: tb/tb_ram36_ctrl.sv
// Directed bench for ram36_ctrl with a behavioural 2-cycle-latency single-port RAM.
module tb_ram36_ctrl;

    localparam int AW = 11;
    localparam int DW = 16;

    typedef struct packed {
        logic [1:0]    vld;
        logic [1:0]    we;
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic [1:0]    rdy;
        logic [1:0]    rv;
        logic [DW-1:0] rd;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, ram_wdata, ram_rdata;
    logic            ram_en, ram_we, init_done;
    logic [AW-1:0]   ram_addr;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] q1, q2;
    vec_t          tbl [0:15];

    always #5 clk = ~clk;

    ram36_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .init_done (init_done)
    );

    // RAM model: array read registered, then output register
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) q1 <= mem[ram_addr];
        q2 <= q1;
    end
    assign ram_rdata = q2;

    function automatic logic [DW-1:0] pat(input int i);
        case (i % 10)
            0: return 16'h0001;
            1: return 16'hAAAA;
            2: return 16'h5555;
            3: return 16'hFFFF;
            4: return 16'hF0F0;
            5: return 16'h0F0F;
            6: return 16'hCCCC;
            7: return 16'h3333;
            8: return 16'h0002;
            default: return 16'h0004;
        endcase
    endfunction

    function automatic vec_t v(input logic [1:0] vld, input logic [1:0] we,
                               input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                               input logic [DW-1:0] da, input logic [DW-1:0] db,
                               input logic [1:0] rdy, input logic [1:0] rv,
                               input logic [DW-1:0] rd);
        vec_t t;
        t.vld = vld; t.we = we; t.aa = aa; t.ab = ab; t.da = da; t.db = db;
        t.rdy = rdy; t.rv = rv; t.rd = rd;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Hold rst across one rising edge and check every reset value, then release at a falling edge
    task automatic reset_check(input string tag);
        req_valid = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_reset"},
              {req_ready, rsp_valid, rsp_data, ram_en, ram_we, ram_addr, ram_wdata, init_done},
              64'h0);
        rst = 1'b0;
    endtask

    // Edge k after reset release issues write of 0 to address k-1; init_done rises at edge 2049
    task automatic do_sweep(input string tag);
        for (int k = 1; k <= 2048; k++) begin
            @(negedge clk);
            check($sformatf("%s_sweep[%0d]", tag, k),
                  {ram_en, ram_we, ram_addr, ram_wdata, req_ready, init_done, rsp_valid},
                  {1'b1, 1'b1, 11'(k - 1), 16'h0000, 2'b00, 1'b0, 2'b00});
        end
        req_valid = 2'b00;
        @(negedge clk);
        check({tag, "_init_done"}, {init_done, ram_en, req_ready, rsp_valid}, {1'b1, 1'b0, 2'b00, 2'b00});
    endtask

    initial begin
        int id;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;

        //          vld    we     aA        aB        dA        dB        rdy    rv     rsp_data
        tbl[0]  = v(2'b11, 2'b10, 11'd2047, 11'd2047, 16'h0000, 16'hAAAA, 2'b01, 2'b00, 16'h0000);
        tbl[1]  = v(2'b10, 2'b10, 11'd0,    11'd2047, 16'h0000, 16'hAAAA, 2'b10, 2'b00, 16'h0000);
        tbl[2]  = v(2'b10, 2'b00, 11'd0,    11'd2047, 16'h0000, 16'h0000, 2'b10, 2'b00, 16'h0000);
        tbl[3]  = v(2'b01, 2'b01, 11'd1,    11'd0,    16'h1111, 16'h0000, 2'b01, 2'b00, 16'h0000);
        tbl[4]  = v(2'b10, 2'b10, 11'd0,    11'd2,    16'h0000, 16'h2222, 2'b10, 2'b01, 16'h0000);
        tbl[5]  = v(2'b11, 2'b00, 11'd1,    11'd2,    16'h0000, 16'h0000, 2'b01, 2'b00, 16'h0000);
        tbl[6]  = v(2'b11, 2'b00, 11'd1,    11'd2,    16'h0000, 16'h0000, 2'b10, 2'b10, 16'hAAAA);
        tbl[7]  = v(2'b11, 2'b00, 11'd1,    11'd2,    16'h0000, 16'h0000, 2'b01, 2'b00, 16'hAAAA);
        tbl[8]  = v(2'b11, 2'b00, 11'd1,    11'd2,    16'h0000, 16'h0000, 2'b10, 2'b00, 16'hAAAA);
        tbl[9]  = v(2'b01, 2'b01, 11'd5,    11'd0,    16'h0001, 16'h0000, 2'b01, 2'b01, 16'h1111);
        tbl[10] = v(2'b01, 2'b00, 11'd5,    11'd0,    16'h0000, 16'h0000, 2'b01, 2'b10, 16'h2222);
        tbl[11] = v(2'b00, 2'b00, 11'd0,    11'd0,    16'h0000, 16'h0000, 2'b00, 2'b01, 16'h1111);
        tbl[12] = v(2'b00, 2'b00, 11'd0,    11'd0,    16'h0000, 16'h0000, 2'b00, 2'b10, 16'h2222);
        tbl[13] = v(2'b00, 2'b00, 11'd0,    11'd0,    16'h0000, 16'h0000, 2'b00, 2'b00, 16'h2222);
        tbl[14] = v(2'b00, 2'b00, 11'd0,    11'd0,    16'h0000, 16'h0000, 2'b00, 2'b01, 16'h0001);
        tbl[15] = v(2'b00, 2'b00, 11'd0,    11'd0,    16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0001);

        reset_check("por");
        do_sweep("por");

        // Contention, alternating reads and write-then-read, one row per cycle
        for (int r = 0; r < 16; r++) begin
            req_valid = tbl[r].vld;
            req_we    = tbl[r].we;
            req_addr  = {tbl[r].ab, tbl[r].aa};
            req_wdata = {tbl[r].db, tbl[r].da};
            #1;
            check($sformatf("row%0d_ready", r), req_ready, tbl[r].rdy);
            check($sformatf("row%0d_rsp_valid", r), rsp_valid, tbl[r].rv);
            check($sformatf("row%0d_rsp_data", r), rsp_data, tbl[r].rd);
            if (r == 0) begin
                check("row0_ram_en", ram_en, 1'b0);
            end else if (tbl[r-1].rdy == 2'b00) begin
                check($sformatf("row%0d_ram_en", r), ram_en, 1'b0);
            end else begin
                id = tbl[r-1].rdy[1] ? 1 : 0;
                check($sformatf("row%0d_ram_cmd", r), {ram_en, ram_we, ram_addr},
                      {1'b1, tbl[r-1].we[id], (id == 1) ? tbl[r-1].ab : tbl[r-1].aa});
                if (tbl[r-1].we[id]) begin
                    check($sformatf("row%0d_ram_wdata", r), ram_wdata,
                          (id == 1) ? tbl[r-1].db : tbl[r-1].da);
                end
            end
            @(negedge clk);
        end

        // Two reads in flight, then reset: nothing may come back, sweep restarts at 0
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {11'd0, 11'd5};
        #1;
        check("inflight0_ready", req_ready, 2'b01);
        @(negedge clk);
        req_addr  = {11'd0, 11'd1};
        #1;
        check("inflight1_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        reset_check("mid");
        do_sweep("mid");

        // Pattern fill of all words by A
        for (int i = 0; i < 2048; i++) begin
            req_valid = 2'b01;
            req_we    = 2'b01;
            req_addr  = {11'd0, 11'(i)};
            req_wdata = {16'h0000, pat(i)};
            #1;
            check($sformatf("fill[%0d]_ready", i), req_ready, 2'b01);
            @(negedge clk);
        end

        // Read back 0..2047 then wrap to 0; each response due 4 cycles after its accept
        for (int i = 0; i <= 2048 + 6; i++) begin
            if (i <= 2048) begin
                req_valid = 2'b01;
                req_we    = 2'b00;
                req_addr  = {11'd0, 11'(i % 2048)};
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (i <= 2048) check($sformatf("rd[%0d]_ready", i), req_ready, 2'b01);
            if (i >= 4 && i <= 2048 + 4) begin
                check($sformatf("rd[%0d]_rsp_valid", i - 4), rsp_valid, 2'b01);
                check($sformatf("rd[%0d]_rsp_data", i - 4), rsp_data, pat((i - 4) % 2048));
            end else begin
                check($sformatf("rd_idle[%0d]_rsp_valid", i), rsp_valid, 2'b00);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
